// File: rtl/idx_mask_builder.sv
// Packs a valid/ready stream of bit indices into a WIDTH-bit mask, one mask per frame,
// with set-bit count and sticky out-of-range / duplicate flags.
//
// state | meaning
// ------+--------------------------------------------------------------
// ACCUM | accepting index beats, mask/pop/errors accumulate
// OUT   | frame complete, mask presented until mask handshake
module idx_mask_builder #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int unsigned POP_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic [CNT_WIDTH-1:0] idx_i,
    input  logic                 idx_last_i,
    input  logic                 idx_valid_i,
    output logic                 idx_ready_o,
    output logic [WIDTH-1:0]     mask_o,
    output logic [POP_WIDTH-1:0] pop_o,
    output logic                 empty_o,
    output logic                 err_oor_o,
    output logic                 err_dup_o,
    output logic                 mask_valid_o,
    input  logic                 mask_ready_i
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mask_q, mask_d;
    logic [POP_WIDTH-1:0] pop_q, pop_d;
    logic                 oor_q, oor_d;
    logic                 dup_q, dup_d;

    logic [31:0]          idx_ext;
    logic [31:0]          pos;
    logic                 in_range;
    logic [WIDTH-1:0]     sel;
    logic                 hit_dup;
    logic                 beat;

    // Index decode: pos is only meaningful when the index is in range.
    always_comb begin
        idx_ext  = 32'(idx_i);
        in_range = (idx_ext < WIDTH);
        pos      = MODE ? (WIDTH - 32'd1 - idx_ext) : idx_ext;
        sel      = '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
            sel[b] = in_range && (pos == 32'(b));
        end
        hit_dup = |(sel & mask_q);
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        pop_d        = pop_q;
        oor_d        = oor_q;
        dup_d        = dup_q;
        idx_ready_o  = (state_q == ACCUM);
        mask_valid_o = (state_q == OUT);
        beat         = idx_valid_i && (state_q == ACCUM);

        case (state_q)
            ACCUM: begin
                if (beat) begin
                    if (!in_range) begin
                        oor_d = 1'b1;
                    end else if (hit_dup) begin
                        dup_d = 1'b1;
                    end else begin
                        mask_d = mask_q | sel;
                        pop_d  = pop_q + POP_WIDTH'(1);
                    end
                    if (idx_last_i) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (mask_ready_i) begin
                    state_d = ACCUM;
                    mask_d  = '0;
                    pop_d   = '0;
                    oor_d   = 1'b0;
                    dup_d   = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        // Abort overrides any beat or output handshake in the same cycle.
        if (clr_i) begin
            state_d = ACCUM;
            mask_d  = '0;
            pop_d   = '0;
            oor_d   = 1'b0;
            dup_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
            mask_q  <= '0;
            pop_q   <= '0;
            oor_q   <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pop_q   <= pop_d;
            oor_q   <= oor_d;
            dup_q   <= dup_d;
        end
    end

    assign mask_o    = mask_q;
    assign pop_o     = pop_q;
    assign empty_o   = ~|mask_q;
    assign err_oor_o = oor_q;
    assign err_dup_o = dup_q;

endmodule

// File: tb/tb_idx_mask_builder.sv
// Bench for idx_mask_builder: four configurations share one input stream and are
// compared every cycle against a frame-level model built from the accepted index list.
module tb_idx_mask_builder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clr, idx_valid, idx_last, mask_ready;
    logic [2:0] idx;

    logic       rdy0, vld0, emp0, oor0, dup0;
    logic [7:0] mask0;
    logic [3:0] pop0;
    logic       rdy1, vld1, emp1, oor1, dup1;
    logic [7:0] mask1;
    logic [3:0] pop1;
    logic       rdy2, vld2, emp2, oor2, dup2;
    logic [4:0] mask2;
    logic [2:0] pop2;
    logic       rdy3, vld3, emp3, oor3, dup3;
    logic [0:0] mask3;
    logic [0:0] pop3;

    idx_mask_builder #(.WIDTH(8), .MODE(1'b0)) u_w8_m0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .idx_i(idx), .idx_last_i(idx_last),
        .idx_valid_i(idx_valid), .idx_ready_o(rdy0), .mask_o(mask0), .pop_o(pop0),
        .empty_o(emp0), .err_oor_o(oor0), .err_dup_o(dup0), .mask_valid_o(vld0),
        .mask_ready_i(mask_ready));

    idx_mask_builder #(.WIDTH(8), .MODE(1'b1)) u_w8_m1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .idx_i(idx), .idx_last_i(idx_last),
        .idx_valid_i(idx_valid), .idx_ready_o(rdy1), .mask_o(mask1), .pop_o(pop1),
        .empty_o(emp1), .err_oor_o(oor1), .err_dup_o(dup1), .mask_valid_o(vld1),
        .mask_ready_i(mask_ready));

    idx_mask_builder #(.WIDTH(5), .MODE(1'b0)) u_w5_m0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .idx_i(idx), .idx_last_i(idx_last),
        .idx_valid_i(idx_valid), .idx_ready_o(rdy2), .mask_o(mask2), .pop_o(pop2),
        .empty_o(emp2), .err_oor_o(oor2), .err_dup_o(dup2), .mask_valid_o(vld2),
        .mask_ready_i(mask_ready));

    idx_mask_builder #(.WIDTH(1), .MODE(1'b0)) u_w1_m0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .idx_i(idx[0:0]), .idx_last_i(idx_last),
        .idx_valid_i(idx_valid), .idx_ready_o(rdy3), .mask_o(mask3), .pop_o(pop3),
        .empty_o(emp3), .err_oor_o(oor3), .err_dup_o(dup3), .mask_valid_o(vld3),
        .mask_ready_i(mask_ready));

    // Observed vector per instance: {ready, valid, dup, oor, empty, pop[3:0], mask[7:0]}
    logic [16:0] obs [4];
    assign obs[0] = {rdy0, vld0, dup0, oor0, emp0, pop0, mask0};
    assign obs[1] = {rdy1, vld1, dup1, oor1, emp1, pop1, mask1};
    assign obs[2] = {rdy2, vld2, dup2, oor2, emp2, 1'b0, pop2, 3'b000, mask2};
    assign obs[3] = {rdy3, vld3, dup3, oor3, emp3, 3'b000, pop3, 7'b0000000, mask3};

    int total = 0;
    int bad   = 0;
    int cfg_w [4] = '{8, 8, 5, 1};
    bit cfg_m [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    // Expected outputs given the list of indices accepted so far in the current frame.
    function automatic logic [16:0] model(input int k, input int q[$], input bit vld);
        int       w = cfg_w[k];
        bit [7:0] m = '0;
        bit       oor = 1'b0;
        bit       dup = 1'b0;
        logic [3:0] pop;
        foreach (q[j]) begin
            int i = (w == 1) ? (q[j] & 1) : q[j];
            if (i >= w) begin
                oor = 1'b1;
            end else begin
                int p = cfg_m[k] ? (w - 1 - i) : i;
                if (m[p]) dup = 1'b1;
                else m[p] = 1'b1;
            end
        end
        pop = 4'($countones(m));
        return {!vld, vld, dup, oor, (m == 8'h00), pop, m};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input int i, input bit last);
        idx       = 3'(i);
        idx_last  = last;
        idx_valid = 1'b1;
        step();
        idx_valid = 1'b0;
        idx_last  = 1'b0;
    endtask

    task automatic test_reset();
        int none[$];
        rst_n = 1'b0;
        clr = 1'b0;
        idx_valid = 1'b1;
        idx_last = 1'b1;
        idx = 3'd3;
        mask_ready = 1'b0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            logic [16:0] exp = model(k, none, 1'b0);
            total++;
            if (obs[k] !== exp) begin
                bad++;
                $display("FAIL reset inst=%0d got=%h want=%h", k, obs[k], exp);
            end
        end
        idx_valid = 1'b0;
        idx_last = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_frame(input string tag, input int q[$]);
        int acc[$];
        int none[$];
        mask_ready = 1'b1;
        foreach (q[j]) begin
            bit last = (j == q.size() - 1);
            beat(q[j], last);
            acc.push_back(q[j]);
            for (int k = 0; k < 4; k++) begin
                logic [16:0] exp = model(k, acc, last);
                total++;
                if (obs[k] !== exp) begin
                    bad++;
                    $display("FAIL %s beat=%0d inst=%0d got=%h want=%h", tag, j, k, obs[k], exp);
                end
            end
        end
        step();
        for (int k = 0; k < 4; k++) begin
            logic [16:0] exp = model(k, none, 1'b0);
            total++;
            if (obs[k] !== exp) begin
                bad++;
                $display("FAIL %s_after_hs inst=%0d got=%h want=%h", tag, k, obs[k], exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int f1[$];
        int f2[$];
        int none[$];
        f1 = {1};
        f2 = {4};
        mask_ready = 1'b0;
        beat(1, 1'b1);
        idx = 3'd4;
        idx_last = 1'b1;
        idx_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 4; k++) begin
                logic [16:0] exp = model(k, f1, 1'b1);
                total++;
                if (obs[k] !== exp) begin
                    bad++;
                    $display("FAIL bp_hold cyc=%0d inst=%0d got=%h want=%h", c, k, obs[k], exp);
                end
            end
            if (c < 4) step();
        end
        mask_ready = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            logic [16:0] exp = model(k, none, 1'b0);
            total++;
            if (obs[k] !== exp) begin
                bad++;
                $display("FAIL bp_bubble inst=%0d got=%h want=%h", k, obs[k], exp);
            end
        end
        step();
        idx_valid = 1'b0;
        idx_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [16:0] exp = model(k, f2, 1'b1);
            total++;
            if (obs[k] !== exp) begin
                bad++;
                $display("FAIL bp_next inst=%0d got=%h want=%h", k, obs[k], exp);
            end
        end
        step();
    endtask

    task automatic test_abort();
        int none[$];
        int f0[$];
        int f5[$];
        f0 = {0};
        f5 = {5};
        mask_ready = 1'b1;
        for (int use_rst = 0; use_rst < 2; use_rst++) begin
            beat(1, 1'b0);
            beat(6, 1'b0);
            if (use_rst == 1) rst_n = 1'b0;
            else clr = 1'b1;
            beat(3, 1'b1);
            clr = 1'b0;
            rst_n = 1'b1;
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 4; k++) begin
                    logic [16:0] exp = model(k, none, 1'b0);
                    total++;
                    if (obs[k] !== exp) begin
                        bad++;
                        $display("FAIL abort rst=%0d cyc=%0d inst=%0d got=%h want=%h",
                                 use_rst, c, k, obs[k], exp);
                    end
                end
                step();
            end
        end
        beat(0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            logic [16:0] exp = model(k, f0, 1'b1);
            total++;
            if (obs[k] !== exp) begin
                bad++;
                $display("FAIL abort_fresh inst=%0d got=%h want=%h", k, obs[k], exp);
            end
        end
        step();
        // Abort while a mask is pending drops it.
        mask_ready = 1'b0;
        beat(5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            logic [16:0] exp = model(k, f5, 1'b1);
            total++;
            if (obs[k] !== exp) begin
                bad++;
                $display("FAIL abort_out_pre inst=%0d got=%h want=%h", k, obs[k], exp);
            end
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [16:0] exp = model(k, none, 1'b0);
            total++;
            if (obs[k] !== exp) begin
                bad++;
                $display("FAIL abort_out inst=%0d got=%h want=%h", k, obs[k], exp);
            end
        end
    endtask

    task automatic test_random();
        int none[$];
        for (int f = 0; f < 40; f++) begin
            int acc[$];
            int n = int'($urandom_range(1, 6));
            for (int j = 0; j < n; j++) begin
                bit last = (j == n - 1);
                int v = int'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) begin
                    idx_valid = 1'b0;
                    idx = 3'($urandom);
                    idx_last = 1'($urandom);
                    mask_ready = 1'($urandom);
                    step();
                    for (int k = 0; k < 4; k++) begin
                        logic [16:0] exp = model(k, acc, 1'b0);
                        total++;
                        if (obs[k] !== exp) begin
                            bad++;
                            $display("FAIL rnd_idle f=%0d inst=%0d got=%h want=%h", f, k, obs[k], exp);
                        end
                    end
                end
                mask_ready = 1'($urandom);
                beat(v, last);
                acc.push_back(v);
                for (int k = 0; k < 4; k++) begin
                    logic [16:0] exp = model(k, acc, last);
                    total++;
                    if (obs[k] !== exp) begin
                        bad++;
                        $display("FAIL rnd_beat f=%0d j=%0d inst=%0d got=%h want=%h", f, j, k, obs[k], exp);
                    end
                end
            end
            mask_ready = 1'b0;
            for (int h = int'($urandom_range(0, 3)); h > 0; h--) begin
                idx_valid = 1'($urandom);
                idx = 3'($urandom);
                idx_last = 1'($urandom);
                step();
                for (int k = 0; k < 4; k++) begin
                    logic [16:0] exp = model(k, acc, 1'b1);
                    total++;
                    if (obs[k] !== exp) begin
                        bad++;
                        $display("FAIL rnd_hold f=%0d inst=%0d got=%h want=%h", f, k, obs[k], exp);
                    end
                end
            end
            idx_valid = 1'($urandom);
            mask_ready = 1'b1;
            step();
            idx_valid = 1'b0;
            idx_last = 1'b0;
            for (int k = 0; k < 4; k++) begin
                logic [16:0] exp = model(k, none, 1'b0);
                total++;
                if (obs[k] !== exp) begin
                    bad++;
                    $display("FAIL rnd_hs f=%0d inst=%0d got=%h want=%h", f, k, obs[k], exp);
                end
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int q[$];
        rst_n = 1'b0;
        clr = 1'b0;
        idx_valid = 1'b0;
        idx_last = 1'b0;
        idx = 3'd0;
        mask_ready = 1'b0;
        @(negedge clk);
        test_reset();
        q = {0, 3, 7};
        test_frame("basic_037", q);
        q = {2, 2, 5};
        test_frame("dup_225", q);
        q = {6, 7};
        test_frame("oor_67", q);
        q = {0};
        test_frame("single_0", q);
        test_backpressure();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
